// File: rtl/wash_cycle_controller_if.sv
// Wash controller bus: start/pause/abort and preset times in,
// phase enables, phase code, busy/paused/done and remaining units out.
interface wash_cycle_controller_if;
  logic       start;
  logic       pause;
  logic       abort;
  logic [4:0] wash_time;
  logic [4:0] rinse_time;
  logic [4:0] spin_time;
  logic       wash_en;
  logic       rinse_en;
  logic       spin_en;
  logic [1:0] phase;
  logic       busy;
  logic       paused;
  logic       done;
  logic [7:0] remaining;

  modport master (
    output start, pause, abort,
    output wash_time, rinse_time, spin_time,
    input  wash_en, rinse_en, spin_en,
    input  phase, busy, paused, done, remaining
  );

  modport slave (
    input  start, pause, abort,
    input  wash_time, rinse_time, spin_time,
    output wash_en, rinse_en, spin_en,
    output phase, busy, paused, done, remaining
  );
endinterface

// File: rtl/wash_cycle_controller.sv
// Wash programme sequencer WASH -> RINSE -> SPIN -> DONE with pause/abort.
// Ports: clk, rst (sync, active-high), bus (slave side of the controller bus).
module wash_cycle_controller #(
  parameter int TICK_DIV = 1
) (
  input logic clk,
  input logic rst,
  wash_cycle_controller_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, WASH, RINSE, SPIN, DONE
  } state_t;

  state_t        state, state_n;
  logic [4:0]    cnt, cnt_n;
  logic [7:0]    rem, rem_n;
  logic [PW-1:0] presc, presc_n;
  logic [4:0]    wl, wl_n;
  logic [4:0]    rl, rl_n;
  logic [4:0]    sl, sl_n;
  logic          run;
  logic          tick;

  assign run  = (state == WASH) || (state == RINSE) ||
                (state == SPIN);
  assign tick = run && !bus.pause && (presc == PMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      presc <= '0;
      wl    <= '0;
      rl    <= '0;
      sl    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rem   <= rem_n;
      presc <= presc_n;
      wl    <= wl_n;
      rl    <= rl_n;
      sl    <= sl_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rem_n   = rem;
    presc_n = presc;
    wl_n    = wl;
    rl_n    = rl;
    sl_n    = sl;
    if (bus.abort) begin
      state_n = IDLE;
      cnt_n   = '0;
      rem_n   = '0;
      presc_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            wl_n    = bus.wash_time;
            rl_n    = bus.rinse_time;
            sl_n    = bus.spin_time;
            rem_n   = {3'b0, bus.wash_time} +
                      {3'b0, bus.rinse_time} +
                      {3'b0, bus.spin_time};
            presc_n = '0;
            // Enter the first non-empty phase directly.
            if (bus.wash_time != '0) begin
              state_n = WASH;
              cnt_n   = bus.wash_time;
            end else if (bus.rinse_time != '0) begin
              state_n = RINSE;
              cnt_n   = bus.rinse_time;
            end else if (bus.spin_time != '0) begin
              state_n = SPIN;
              cnt_n   = bus.spin_time;
            end else begin
              state_n = DONE;
              cnt_n   = '0;
            end
          end
        end
        WASH, RINSE, SPIN: begin
          if (!bus.pause) begin
            if (tick) begin
              presc_n = '0;
              rem_n   = rem - 8'd1;
              if (cnt == 5'd1) begin
                // Last unit of this phase: skip empty successors.
                if (state == WASH && rl != '0) begin
                  state_n = RINSE;
                  cnt_n   = rl;
                end else if (state != SPIN && sl != '0) begin
                  state_n = SPIN;
                  cnt_n   = sl;
                end else begin
                  state_n = DONE;
                  cnt_n   = '0;
                end
              end else begin
                cnt_n = cnt - 5'd1;
              end
            end else begin
              presc_n = presc + PW'(1);
            end
          end
        end
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.phase = 2'd0;
    unique case (1'b1)
      state == WASH:  bus.phase = 2'd1;
      state == RINSE: bus.phase = 2'd2;
      state == SPIN:  bus.phase = 2'd3;
      default:        bus.phase = 2'd0;
    endcase
  end

  assign bus.wash_en   = (state == WASH) && !bus.pause;
  assign bus.rinse_en  = (state == RINSE) && !bus.pause;
  assign bus.spin_en   = (state == SPIN) && !bus.pause;
  assign bus.busy      = run;
  assign bus.paused    = run && bus.pause;
  assign bus.done      = (state == DONE);
  assign bus.remaining = rem;

endmodule

// File: tb/tb_wash_cycle_controller.sv
// Bench for wash_cycle_controller: TICK_DIV=1 and TICK_DIV=4 instances
// checked each cycle against a time-based reference model.
module tb_wash_cycle_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, pause, abort;
  logic [4:0] wt, rt, st;

  wash_cycle_controller_if b1 ();
  wash_cycle_controller_if b4 ();

  assign b1.start = start;
  assign b1.pause = pause;
  assign b1.abort = abort;
  assign b1.wash_time = wt;
  assign b1.rinse_time = rt;
  assign b1.spin_time = st;
  assign b4.start = start;
  assign b4.pause = pause;
  assign b4.abort = abort;
  assign b4.wash_time = wt;
  assign b4.rinse_time = rt;
  assign b4.spin_time = st;

  wash_cycle_controller #(.TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave)
  );
  wash_cycle_controller #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .bus(b4.slave)
  );

  // Model: a programme is the elapsed count of unpaused busy cycles;
  // phase and remaining follow from cumulative phase boundaries.
  typedef struct {
    bit run;
    bit done;
    int t;
    int lw;
    int lr;
    int ls;
    int d;
  } mdl_t;

  typedef struct {
    logic       start;
    logic [1:0] ph;
    logic [2:0] en;
    logic [7:0] rem;
    logic       done;
  } vec_t;

  mdl_t m1, m4;
  vec_t tbl [11];
  int   tests = 0;
  int   fails = 0;
  int   cyc_no = 0;
  int   k;

  function automatic mdl_t mstep(mdl_t m, bit rs, bit sa,
                                 bit pa, bit ab,
                                 int w, int r, int s);
    if (rs) begin
      m.run = 0; m.done = 0; m.t = 0;
      m.lw = 0; m.lr = 0; m.ls = 0;
    end else if (ab) begin
      m.run = 0; m.done = 0; m.t = 0;
    end else if (m.done) begin
      m.done = 0;
    end else if (m.run) begin
      if (!pa) begin
        m.t++;
        if (m.t == (m.lw + m.lr + m.ls) * m.d) begin
          m.run = 0;
          m.done = 1;
        end
      end
    end else if (sa) begin
      m.lw = w; m.lr = r; m.ls = s; m.t = 0;
      if (w + r + s == 0) m.done = 1;
      else m.run = 1;
    end
    return m;
  endfunction

  // {wash_en, rinse_en, spin_en, phase, busy, paused, done, remaining}
  function automatic logic [15:0] mout(mdl_t m, logic pa);
    logic [15:0] o;
    int u, ph;
    o = '0;
    if (m.done) begin
      o[8] = 1'b1;
    end else if (m.run) begin
      u = m.t / m.d;
      if (m.t < m.lw * m.d) ph = 1;
      else if (m.t < (m.lw + m.lr) * m.d) ph = 2;
      else ph = 3;
      o[12:11] = ph[1:0];
      o[10] = 1'b1;
      o[9] = pa;
      if (!pa) o[16-ph] = 1'b1;
      o[7:0] = 8'(m.lw + m.lr + m.ls - u);
    end
    return o;
  endfunction

  function automatic logic [15:0] act1();
    return {b1.wash_en, b1.rinse_en, b1.spin_en, b1.phase,
            b1.busy, b1.paused, b1.done, b1.remaining};
  endfunction

  function automatic logic [15:0] act4();
    return {b4.wash_en, b4.rinse_en, b4.spin_en, b4.phase,
            b4.busy, b4.paused, b4.done, b4.remaining};
  endfunction

  function automatic vec_t mkv(logic s, logic [1:0] p,
                               logic [2:0] e, logic [7:0] r,
                               logic d);
    vec_t v;
    v.start = s; v.ph = p; v.en = e; v.rem = r; v.done = d;
    return v;
  endfunction

  task automatic chk(string name, logic [15:0] a, logic [15:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h",
               name, cyc_no, a, e);
    end
  endtask

  task automatic chkv(string name, int a, int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0d expected %0d",
               name, cyc_no, a, e);
    end
  endtask

  task automatic cyc();
    m1 = mstep(m1, rst, start, pause, abort, wt, rt, st);
    m4 = mstep(m4, rst, start, pause, abort, wt, rt, st);
    @(posedge clk);
    #1;
    cyc_no++;
    chk("model_div1", act1(), mout(m1, pause));
    chk("model_div4", act4(), mout(m4, pause));
  endtask

  task automatic run_to(int n);
    while (cyc_no < k + n) cyc();
  endtask

  task automatic do_reset();
    rst = 1; start = 0; pause = 0; abort = 0;
    cyc();
    rst = 0;
    chk("reset_state", act1(), 16'h0);
  endtask

  task automatic launch(int w, int r, int s);
    wt = 5'(w); rt = 5'(r); st = 5'(s);
    k = cyc_no;
    start = 1;
    cyc();
    start = 0;
  endtask

  initial begin
    tbl[0]  = mkv(1, 1, 3'b100, 9, 0);
    tbl[1]  = mkv(0, 1, 3'b100, 8, 0);
    tbl[2]  = mkv(0, 1, 3'b100, 7, 0);
    tbl[3]  = mkv(0, 2, 3'b010, 6, 0);
    tbl[4]  = mkv(0, 2, 3'b010, 5, 0);
    tbl[5]  = mkv(0, 3, 3'b001, 4, 0);
    tbl[6]  = mkv(0, 3, 3'b001, 3, 0);
    tbl[7]  = mkv(0, 3, 3'b001, 2, 0);
    tbl[8]  = mkv(0, 3, 3'b001, 1, 0);
    tbl[9]  = mkv(0, 0, 3'b000, 0, 1);
    tbl[10] = mkv(0, 0, 3'b000, 0, 0);

    m1 = '{0, 0, 0, 0, 0, 0, 1};
    m4 = '{0, 0, 0, 0, 0, 0, 4};
    rst = 1; start = 0; pause = 0; abort = 0;
    wt = 0; rt = 0; st = 0;
    do_reset();

    // Basic programme 3/2/4 from a vector table
    wt = 3; rt = 2; st = 4;
    for (int i = 0; i < 11; i++) begin
      start = tbl[i].start;
      cyc();
      tests++;
      if ({b1.phase, b1.wash_en, b1.rinse_en, b1.spin_en,
           b1.remaining, b1.done} !==
          {tbl[i].ph, tbl[i].en, tbl[i].rem, tbl[i].done}) begin
        fails++;
        $display("FAIL table row %0d: got ph=%0d en=%b rem=%0d done=%b expected ph=%0d en=%b rem=%0d done=%b",
                 i, b1.phase, {b1.wash_en, b1.rinse_en, b1.spin_en},
                 b1.remaining, b1.done, tbl[i].ph, tbl[i].en,
                 tbl[i].rem, tbl[i].done);
      end
    end
    start = 0;

    // Zero-length phases skipped
    do_reset();
    launch(0, 2, 0);
    chkv("zskip_ph_k1", b1.phase, 2);
    run_to(2);
    chkv("zskip_ph_k2", b1.phase, 2);
    run_to(3);
    chkv("zskip_done", b1.done, 1);
    do_reset();
    launch(0, 0, 0);
    chkv("allzero_done", b1.done, 1);
    run_to(2);
    chkv("allzero_idle", b1.done, 0);

    // Pause for five cycles from k+2
    do_reset();
    launch(3, 2, 4);
    cyc();
    pause = 1;
    #1;
    chkv("pause_flag", b1.paused, 1);
    chkv("pause_wash_en", b1.wash_en, 0);
    run_to(7);
    chkv("pause_rem_held", b1.remaining, 8);
    pause = 0;
    run_to(8);
    chkv("pause_wash_end", b1.phase, 1);
    run_to(9);
    chkv("pause_rinse", b1.phase, 2);
    run_to(15);
    chkv("pause_done", b1.done, 1);

    // Abort, then restart
    do_reset();
    launch(3, 2, 4);
    run_to(5);
    abort = 1;
    cyc();
    abort = 0;
    chk("abort_idle", act1(), 16'h0);
    launch(3, 2, 4);
    run_to(10);
    chkv("abort_rerun_done", b1.done, 1);

    // Same with reset mid-run
    do_reset();
    launch(3, 2, 4);
    run_to(5);
    rst = 1;
    cyc();
    rst = 0;
    chk("rst_idle", act1(), 16'h0);
    launch(3, 2, 4);
    run_to(10);
    chkv("rst_rerun_done", b1.done, 1);

    // TICK_DIV=4 programme 1/0/1
    do_reset();
    launch(1, 0, 1);
    chkv("div4_wash_k1", b4.wash_en, 1);
    run_to(4);
    chkv("div4_wash_k4", b4.wash_en, 1);
    chkv("div4_rem_k4", b4.remaining, 2);
    run_to(5);
    chkv("div4_spin_k5", b4.spin_en, 1);
    chkv("div4_rem_k5", b4.remaining, 1);
    run_to(8);
    chkv("div4_spin_k8", b4.spin_en, 1);
    run_to(9);
    chkv("div4_done", b4.done, 1);

    // Preset change and start during RINSE are ignored
    do_reset();
    launch(3, 2, 4);
    run_to(4);
    wt = 7; rt = 7; st = 7;
    start = 1;
    cyc();
    start = 0;
    chkv("ign_rinse", b1.phase, 2);
    run_to(10);
    chkv("ign_done", b1.done, 1);

    // Pause and abort in IDLE
    do_reset();
    pause = 1;
    cyc();
    chk("idle_pause", act1(), 16'h0);
    pause = 0;
    abort = 1;
    cyc();
    chk("idle_abort", act1(), 16'h0);
    abort = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      abort = ($urandom_range(0, 39) == 0);
      pause = ($urandom_range(0, 5) == 0);
      start = ($urandom_range(0, 3) == 0);
      wt = ($urandom_range(0, 3) == 0) ? 5'd0
           : 5'($urandom_range(1, 6));
      rt = ($urandom_range(0, 3) == 0) ? 5'd0
           : 5'($urandom_range(1, 6));
      st = ($urandom_range(0, 15) == 0) ? 5'd31
           : 5'($urandom_range(0, 6));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wash_cycle_controller.md
Name: wash_cycle_controller

Overview:
- Sequences one wash programme: WASH → RINSE → SPIN → DONE.
- Phase durations come from the preset store's wash/rinse/spin outputs (5 bits each, in time units).
- Drives one-hot phase enables to the motor/valve logic, plus a remaining-time count that matches the store's wash+rinse+spin total.
- Handles start, pause and abort requests.

Parameters:
TICK_DIV, 1, clock cycles per time unit (≥1; 1 for simulation, large on hardware)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  begin programme; accepted only in IDLE
pause  input  1  level; freezes the running programme while high
abort  input  1  cancels the programme; returns to IDLE
wash_time  input  5  wash duration in units
rinse_time  input  5  rinse duration in units
spin_time  input  5  spin duration in units
wash_en  output  1  high in WASH and not paused
rinse_en  output  1  high in RINSE and not paused
spin_en  output  1  high in SPIN and not paused
phase  output  2  0=IDLE/DONE, 1=WASH, 2=RINSE, 3=SPIN
busy  output  1  high in WASH/RINSE/SPIN, including while paused
paused  output  1  busy and pause high (combinational from pause)
done  output  1  one-cycle pulse in DONE
remaining  output  8  units left in the programme

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; all enables, busy and done 0; phase 0; remaining 0; prescaler 0; latched times 0.
- Priority at each edge: rst > abort > pause > start/tick.
- States: IDLE, WASH, RINSE, SPIN, DONE, all registered. Outputs decode from the state register; paused also uses pause directly.
- IDLE, start=1 at edge k:
  - Latch the three times.
  - remaining ← wash+rinse+spin, zero-extended to 8 bits (max 93, no overflow).
  - Clear the prescaler.
  - Go to the first phase in order WASH, RINSE, SPIN whose latched time is non-zero; load that phase's counter.
  - All three zero → DONE at k+1.
- Time changes while busy are ignored; latched values are used.
- Tick: prescaler counts 0..TICK_DIV-1 only while busy and pause=0. Tick is asserted when the prescaler equals TICK_DIV-1. With TICK_DIV=1, tick is every busy, unpaused cycle.
- On each tick in a phase:
  - remaining decrements by 1.
  - Phase counter = 1: move to the next non-zero phase and load its counter; if none remain, go to DONE.
  - Otherwise the phase counter decrements by 1.
  - A phase of N units therefore lasts exactly N·TICK_DIV unpaused cycles. Zero-length phases take no cycles.
- Pause (pause=1, busy):
  - State, counters, prescaler and remaining are held.
  - Enables are 0; phase and busy are held.
  - Pause in IDLE or DONE has no effect.
  - start with pause=1 still enters the first phase, paused.
- Abort (abort=1): from any state, IDLE next cycle, all outputs as after reset except the latched times. Abort in IDLE has no effect.
- DONE: lasts exactly one cycle with done=1 and remaining=0, then IDLE. start in DONE is ignored. start high in the following IDLE cycle launches a new run.
- start while busy is ignored.
- Reset mid-run gives the same result as abort.

Test Plan:
1. TICK_DIV=1; wash=3, rinse=2, spin=4; start at edge k →
   - wash_en cycles k+1..k+3, rinse_en k+4..k+5, spin_en k+6..k+9;
   - remaining 9,8,7,6,5,4,3,2,1 over those cycles;
   - done=1, remaining=0 at k+10; IDLE at k+11.
2. Zero skip, TICK_DIV=1:
   - wash=0, rinse=2, spin=0; start at k → RINSE k+1..k+2, DONE k+3, never wash_en or spin_en.
   - All times 0 → DONE at k+1.
3. Pause: scenario 1 with pause high for 5 cycles from k+2 →
   - wash_en=0, paused=1, remaining held at 8;
   - wash ends at k+8, done at k+15.
4. Abort:
   - abort at k+5 in scenario 1 → IDLE at k+6; all outputs 0.
   - start at k+6 → full programme reruns with the latched-at-start times.
   - Repeat using rst instead of abort; same result.
5. TICK_DIV=4; wash=1, rinse=0, spin=1; start at k →
   - wash_en k+1..k+4, spin_en k+5..k+8, done at k+9;
   - remaining 2 then 1, each held 4 cycles.
6. Ignored inputs:
   - Change presets and pulse start during RINSE of scenario 1 → timing unchanged.
   - pause or abort in IDLE → no output change.
